// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, parity/framing/break detection
// and a show-ahead receive FIFO with valid/ready pop and sticky overflow.
module uart_rx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int OVERSAMPLING = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                 CLK,
  input  logic                                 NRST,
  input  logic                                 DIVPULSE,
  input  logic                                 RX_DSER,
  output logic [DATA_BITS-1:0]                 RX_DO,
  output logic                                 RX_PERR,
  output logic                                 RX_FERR,
  output logic                                 RX_VALID,
  input  logic                                 RX_READY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      RX_LEVEL,
  output logic                                 RX_OVR,
  input  logic                                 RX_OVR_CLR,
  output logic                                 RX_BREAK,
  output logic                                 RX_BUSY
);

  localparam int TW = $clog2(OVERSAMPLING);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int EW = DATA_BITS + 2;

  localparam logic [TW-1:0] TC_S0   = TW'(OVERSAMPLING / 2 - 1);
  localparam logic [TW-1:0] TC_S1   = TW'(OVERSAMPLING / 2);
  localparam logic [TW-1:0] TC_DEC  = TW'(OVERSAMPLING / 2 + 1);
  localparam logic [TW-1:0] TC_LAST = TW'(OVERSAMPLING - 1);

  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic          PAR_ODD   = (PARITY_MODE == 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START    = 3'd1;
  localparam logic [2:0] DATA     = 3'd2;
  localparam logic [2:0] PARITY   = 3'd3;
  localparam logic [2:0] STOP     = 3'd4;
  localparam logic [2:0] BRK_WAIT = 3'd5;

  logic                 sync1, sync2;
  logic [2:0]           state;
  logic [TW-1:0]        tc;
  logic [BW-1:0]        bit_cnt;
  logic                 samp0, samp1;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 perr_r;
  logic                 ferr_r;
  logic                 brk_pulse;

  logic                 voted;
  logic                 stop_dec;
  logic                 is_break;
  logic                 push_req;
  logic                 frame_ferr;

  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [LW-1:0]        level;
  logic                 ovr;
  logic                 pop;
  logic                 full;
  logic                 do_write;
  logic [EW-1:0]        head;

  always_ff @(posedge CLK or posedge NRST) begin
    if (NRST) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= RX_DSER;
      sync2 <= sync1;
    end
  end

  // The third vote is the live line on the decision tick itself.
  assign voted      = (samp0 & samp1) | (samp0 & sync2) | (samp1 & sync2);
  assign stop_dec   = DIVPULSE && (state == STOP) && (tc == TC_DEC);
  assign is_break   = stop_dec && (bit_cnt == '0) && (shift == '0) &&
                      ((PARITY_MODE == 0) || !par_bit) && !voted;
  assign push_req   = stop_dec && !is_break && (bit_cnt == LAST_STOP);
  assign frame_ferr = ferr_r | ~voted;

  always_ff @(posedge CLK or posedge NRST) begin
    if (NRST) begin
      state     <= IDLE;
      tc        <= '0;
      bit_cnt   <= '0;
      samp0     <= 1'b1;
      samp1     <= 1'b1;
      shift     <= '0;
      par_bit   <= 1'b0;
      perr_r    <= 1'b0;
      ferr_r    <= 1'b0;
      brk_pulse <= 1'b0;
    end else begin
      brk_pulse <= 1'b0;
      if (DIVPULSE) begin
        case (state)
          IDLE: begin
            if (!sync2) begin
              state   <= START;
              tc      <= '0;
              bit_cnt <= '0;
              ferr_r  <= 1'b0;
              perr_r  <= 1'b0;
            end
          end
          BRK_WAIT: begin
            if (sync2) state <= IDLE;
          end
          default: begin
            tc <= (tc == TC_LAST) ? '0 : tc + 1'b1;
            if (tc == TC_S0) samp0 <= sync2;
            if (tc == TC_S1) samp1 <= sync2;
            case (state)
              START: begin
                if (tc == TC_DEC && voted) state <= IDLE;
                else if (tc == TC_LAST)    state <= DATA;
              end
              DATA: begin
                if (tc == TC_DEC) shift <= {voted, shift[DATA_BITS-1:1]};
                if (tc == TC_LAST) begin
                  if (bit_cnt == LAST_DATA) begin
                    bit_cnt <= '0;
                    state   <= (PARITY_MODE != 0) ? PARITY : STOP;
                  end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                  end
                end
              end
              PARITY: begin
                if (tc == TC_DEC) begin
                  par_bit <= voted;
                  perr_r  <= ((^shift) ^ voted) != PAR_ODD;
                end
                if (tc == TC_LAST) state <= STOP;
              end
              STOP: begin
                // The last stop bit completes mid-bit so a back-to-back start edge is seen.
                if (tc == TC_DEC) begin
                  if (is_break) begin
                    brk_pulse <= 1'b1;
                    state     <= BRK_WAIT;
                  end else if (bit_cnt == LAST_STOP) begin
                    state <= IDLE;
                  end else begin
                    ferr_r <= ferr_r | ~voted;
                  end
                end
                if (tc == TC_LAST) bit_cnt <= bit_cnt + 1'b1;
              end
              default: state <= IDLE;
            endcase
          end
        endcase
      end
    end
  end

  assign pop      = RX_VALID && RX_READY;
  assign full     = (level == FULL_LVL);
  assign do_write = push_req && (!full || pop);

  always_ff @(posedge CLK) begin
    if (do_write) mem[wptr] <= {frame_ferr, perr_r, shift};
  end

  // A push into a full FIFO is still accepted when the head is popped on the same edge.
  always_ff @(posedge CLK or posedge NRST) begin
    if (NRST) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovr   <= 1'b0;
    end else begin
      if (do_write) wptr <= wptr + 1'b1;
      if (pop)      rptr <= rptr + 1'b1;
      case ({do_write, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (push_req && full && !pop) ovr <= 1'b1;
      else if (RX_OVR_CLR)          ovr <= 1'b0;
    end
  end

  assign head     = mem[rptr];
  assign RX_VALID = (level != '0);
  assign RX_DO    = RX_VALID ? head[DATA_BITS-1:0] : '0;
  assign RX_PERR  = RX_VALID ? head[DATA_BITS]     : 1'b0;
  assign RX_FERR  = RX_VALID ? head[DATA_BITS+1]   : 1'b0;
  assign RX_LEVEL = level;
  assign RX_OVR   = ovr;
  assign RX_BREAK = brk_pulse;
  assign RX_BUSY  = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a default 8N1 instance and an even-parity
// instance, random and directed frames, queue-based expected words.
module tb_uart_rx_fifo;

  localparam int DB      = 8;
  localparam int OS      = 8;
  localparam int DEPTH   = 4;
  localparam int LW      = $clog2(DEPTH + 1);
  localparam int DIV     = 16;
  localparam int BIT_CLK = OS * DIV;

  logic          CLK = 1'b0;
  logic          NRST = 1'b0;
  logic          DIVPULSE = 1'b0;
  logic          rx = 1'b1;
  logic          rx_p = 1'b1;
  logic          rx_ready = 1'b1;
  logic          rdy_p = 1'b1;
  logic          ovr_clr = 1'b0;
  logic          ovr_clr_p = 1'b0;

  logic [DB-1:0] do_m, do_p;
  logic          perr_m, ferr_m, valid_m, ovr_m, brk_m, busy_m;
  logic          perr_p, ferr_p, valid_p, ovr_p, brk_p, busy_p;
  logic [LW-1:0] level_m, level_p;

  int            checks = 0;
  int            passed = 0;
  int            brk_seen = 0;
  int            brk_seen_p = 0;
  int            exp_brk = 0;
  logic          exp_ovr = 1'b0;
  int            div_cnt = 0;
  logic [9:0]    exp_q[$];
  logic [9:0]    exp_qp[$];

  uart_rx_fifo dut (
    .CLK(CLK), .NRST(NRST), .DIVPULSE(DIVPULSE), .RX_DSER(rx),
    .RX_DO(do_m), .RX_PERR(perr_m), .RX_FERR(ferr_m), .RX_VALID(valid_m),
    .RX_READY(rx_ready), .RX_LEVEL(level_m), .RX_OVR(ovr_m),
    .RX_OVR_CLR(ovr_clr), .RX_BREAK(brk_m), .RX_BUSY(busy_m)
  );

  uart_rx_fifo #(.PARITY_MODE(2)) dut_p (
    .CLK(CLK), .NRST(NRST), .DIVPULSE(DIVPULSE), .RX_DSER(rx_p),
    .RX_DO(do_p), .RX_PERR(perr_p), .RX_FERR(ferr_p), .RX_VALID(valid_p),
    .RX_READY(rdy_p), .RX_LEVEL(level_p), .RX_OVR(ovr_p),
    .RX_OVR_CLR(ovr_clr_p), .RX_BREAK(brk_p), .RX_BUSY(busy_p)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (div_cnt == DIV - 1) begin
      div_cnt  <= 0;
      DIVPULSE <= 1'b1;
    end else begin
      div_cnt  <= div_cnt + 1;
      DIVPULSE <= 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Monitors: every accepted pop is compared against the oldest expected word.
  always @(negedge CLK) begin
    if (!NRST && valid_m && rx_ready) begin
      if (exp_q.size() == 0) checkOutput("main_extra_word", {22'd0, ferr_m, perr_m, do_m}, 32'h0);
      else checkOutput("main_word", {22'd0, ferr_m, perr_m, do_m}, {22'd0, exp_q.pop_front()});
    end
    if (!NRST && valid_p && rdy_p) begin
      if (exp_qp.size() == 0) checkOutput("par_extra_word", {22'd0, ferr_p, perr_p, do_p}, 32'h0);
      else checkOutput("par_word", {22'd0, ferr_p, perr_p, do_p}, {22'd0, exp_qp.pop_front()});
    end
    if (brk_m) brk_seen++;
    if (brk_p) brk_seen_p++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_line(input int inst, input logic v);
    if (inst == 0) rx = v;
    else rx_p = v;
  endtask

  task automatic drive_bit(input int inst, input logic v, input logic spike);
    if (!spike) begin
      set_line(inst, v);
      tick(BIT_CLK);
    end else begin
      set_line(inst, 1'b1);
      tick(5 * DIV);
      set_line(inst, 1'b0);
      tick(DIV);
      set_line(inst, 1'b1);
      tick(BIT_CLK - 6 * DIV);
    end
  endtask

  // Even parity on instance 1: the correct bit makes the total XOR zero.
  task automatic applyStimulus(input int inst, input logic [7:0] data, input logic par_flip,
                               input logic stop_val, input int spike_bit);
    logic       pbit;
    logic [9:0] exp;
    pbit = (^data) ^ par_flip;
    exp  = {~stop_val, (inst == 1) ? ((^data) ^ pbit) : 1'b0, data};
    if (inst == 0) begin
      if (!rx_ready && exp_q.size() >= DEPTH) exp_ovr = 1'b1;
      else exp_q.push_back(exp);
    end else begin
      exp_qp.push_back(exp);
    end
    drive_bit(inst, 1'b0, 1'b0);
    for (int i = 0; i < DB; i++) drive_bit(inst, data[i], i == spike_bit);
    if (inst == 1) drive_bit(inst, pbit, 1'b0);
    drive_bit(inst, stop_val, 1'b0);
  endtask

  task automatic wait_drain(input int inst);
    int n;
    n = 0;
    while (((inst == 0) ? exp_q.size() : exp_qp.size()) != 0 && n < 4000) begin
      tick(1);
      n++;
    end
    checkOutput((inst == 0) ? "main_drain" : "par_drain",
                (inst == 0) ? exp_q.size() : exp_qp.size(), 0);
  endtask

  initial begin
    #2 NRST = 1'b1;
    tick(3);
    checkOutput("rst_valid", valid_m, 0);
    checkOutput("rst_level", level_m, 0);
    checkOutput("rst_ovr", ovr_m, 0);
    checkOutput("rst_busy", busy_m, 0);
    checkOutput("rst_break", brk_m, 0);
    checkOutput("rst_do", do_m, 0);
    NRST = 1'b0;
    tick(2 * BIT_CLK);

    // Random back-to-back 8N1 bytes
    for (int i = 0; i < 16; i++) applyStimulus(0, 8'($urandom_range(0, 255)), 1'b0, 1'b1, -1);
    set_line(0, 1'b1);
    tick(2 * BIT_CLK);
    wait_drain(0);
    checkOutput("t1_ovr", ovr_m, exp_ovr);
    checkOutput("t1_level", level_m, exp_q.size());

    applyStimulus(1, 8'hA5, 1'b0, 1'b1, -1);
    applyStimulus(1, 8'hA5, 1'b1, 1'b1, -1);
    set_line(1, 1'b1);
    tick(BIT_CLK);
    wait_drain(1);

    // Stop bit low, line returns high one bit later
    applyStimulus(0, 8'h3C, 1'b0, 1'b0, -1);
    set_line(0, 1'b1);
    tick(2 * BIT_CLK);
    applyStimulus(0, 8'h55, 1'b0, 1'b1, -1);
    set_line(0, 1'b1);
    tick(BIT_CLK);
    wait_drain(0);

    rx_ready = 1'b0;
    for (int v = 1; v <= 6; v++) applyStimulus(0, 8'(v), 1'b0, 1'b1, -1);
    set_line(0, 1'b1);
    tick(2 * BIT_CLK);
    checkOutput("t4_level_full", level_m, exp_q.size());
    checkOutput("t4_ovr_set", ovr_m, exp_ovr);
    checkOutput("t4_valid", valid_m, 1);
    rx_ready = 1'b1;
    wait_drain(0);
    tick(2);
    checkOutput("t4_level_empty", level_m, exp_q.size());
    checkOutput("t4_ovr_sticky", ovr_m, exp_ovr);
    checkOutput("t4_do_gated", do_m, 0);
    ovr_clr = 1'b1;
    exp_ovr = 1'b0;
    tick(1);
    ovr_clr = 1'b0;
    tick(1);
    checkOutput("t4_ovr_clr", ovr_m, exp_ovr);

    set_line(0, 1'b0);
    exp_brk++;
    tick(12 * BIT_CLK);
    set_line(0, 1'b1);
    tick(2 * BIT_CLK);
    checkOutput("t5_break_count", brk_seen, exp_brk);
    checkOutput("t5_level", level_m, 0);
    checkOutput("t5_busy", busy_m, 0);
    applyStimulus(0, 8'h7E, 1'b0, 1'b1, -1);
    set_line(0, 1'b1);
    tick(BIT_CLK);
    wait_drain(0);

    // Half-bit glitch must be rejected as a false start
    set_line(0, 1'b0);
    tick(BIT_CLK / 2);
    set_line(0, 1'b1);
    tick(3 * BIT_CLK);
    checkOutput("t6_busy", busy_m, 0);
    checkOutput("t6_level", level_m, 0);
    applyStimulus(0, 8'hFF, 1'b0, 1'b1, 3);
    set_line(0, 1'b1);
    tick(BIT_CLK);
    wait_drain(0);

    rx_ready = 1'b0;
    applyStimulus(0, 8'h11, 1'b0, 1'b1, -1);
    set_line(0, 1'b1);
    tick(BIT_CLK);
    checkOutput("t7_level_pre", level_m, exp_q.size());
    set_line(0, 1'b0);
    tick(3 * BIT_CLK);
    checkOutput("t7_busy_pre", busy_m, 1);
    NRST = 1'b1;
    exp_q.delete();
    tick(2);
    checkOutput("t7_level", level_m, 0);
    checkOutput("t7_valid", valid_m, 0);
    checkOutput("t7_busy", busy_m, 0);
    set_line(0, 1'b1);
    NRST = 1'b0;
    tick(2 * BIT_CLK);
    rx_ready = 1'b1;
    applyStimulus(0, 8'h99, 1'b0, 1'b1, -1);
    set_line(0, 1'b1);
    tick(BIT_CLK);
    wait_drain(0);

    checkOutput("final_break_count", brk_seen, exp_brk);
    checkOutput("final_par_break", brk_seen_p, 0);
    checkOutput("final_ovr", ovr_m, exp_ovr);
    checkOutput("final_par_ovr", ovr_p, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
